// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        SBC = 2'd3
    } addsub_op_e;

    // Subtracting ops add the one's complement of B.
    function automatic logic op_inverts_b(addsub_op_e op);
        return (op == SUB) || (op == SBC);
    endfunction

    // Carry fed into the lowest chunk: fixed for ADD/SUB, external for ADC/SBC.
    function automatic logic op_stage0_cin(addsub_op_e op, logic cin);
        logic c;
        case (op)
            ADD:     c = 1'b0;
            SUB:     c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit slice of the carry chain. Besides the sum and carry
// out it exposes the carry into its MSB so the last slice can form overflow.
module addsub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in,
    output logic         zero
);

    logic [W:0] sum;

    // Widened add gives carry out directly; carry into MSB recovered from the MSB sum bit.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s        = sum[W-1:0];
        cout     = sum[W];
        c_msb_in = a[W-1] ^ b[W-1] ^ sum[W-1];
        zero     = ~|sum[W-1:0];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor. Each stage resolves one
// CHUNK of the carry chain; unprocessed operand chunks travel with the op
// and finished result chunks accumulate. The last stage rank is the output.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end

    // Per-rank pipeline registers
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q   [STAGES];
    logic             zero_q  [STAGES];

    // Per-stage combinational inputs and next values
    logic [WIDTH-1:0] a_d       [STAGES];
    logic [WIDTH-1:0] b_d       [STAGES];
    logic [WIDTH-1:0] res_base  [STAGES];
    logic             cin_d     [STAGES];
    logic             zero_base [STAGES];
    logic [CHUNK-1:0] chunk_a   [STAGES];
    logic [CHUNK-1:0] chunk_b   [STAGES];
    logic [CHUNK-1:0] chunk_s   [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_cmsb [STAGES];
    logic             chunk_zero [STAGES];
    logic [WIDTH-1:0] res_d     [STAGES];
    logic             zero_d    [STAGES];
    logic             ovf_d     [STAGES];

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_first;

    // Handshake: whole pipe moves together whenever the output slot can drain.
    always_comb begin
        adv     = out_ready | ~valid_q[STAGES-1];
        accept  = in_valid & adv & ~flush;
        b_first = op_inverts_b(addsub_op_e'(in_op)) ? ~in_b : in_b;
    end

    assign in_ready = adv & ~flush;

    // Select each stage's source (port inputs for stage 0, previous rank otherwise).
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            int p;
            p = (i > 0) ? i - 1 : 0;
            if (i == 0) begin
                a_d[i]       = in_a;
                b_d[i]       = b_first;
                cin_d[i]     = op_stage0_cin(addsub_op_e'(in_op), in_cin);
                res_base[i]  = '0;
                zero_base[i] = 1'b1;
            end else begin
                a_d[i]       = a_q[p];
                b_d[i]       = b_q[p];
                cin_d[i]     = carry_q[p];
                res_base[i]  = res_q[p];
                zero_base[i] = zero_q[p];
            end
            chunk_a[i] = a_d[i][i*CHUNK +: CHUNK];
            chunk_b[i] = b_d[i][i*CHUNK +: CHUNK];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        addsub_chunk #(.W(CHUNK)) u_chunk (
            .a        (chunk_a[g]),
            .b        (chunk_b[g]),
            .cin      (cin_d[g]),
            .s        (chunk_s[g]),
            .cout     (chunk_cout[g]),
            .c_msb_in (chunk_cmsb[g]),
            .zero     (chunk_zero[g])
        );
    end

    // Merge each chunk result into the accumulated word and flags.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            res_d[i]                   = res_base[i];
            res_d[i][i*CHUNK +: CHUNK] = chunk_s[i];
            zero_d[i]                  = zero_base[i] & chunk_zero[i];
            ovf_d[i]                   = chunk_cout[i] ^ chunk_cmsb[i];
        end
    end

    // Pipeline registers: flush clears valids only; data moves only when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                res_q[i]   <= '0;
                carry_q[i] <= 1'b0;
                ovf_q[i]   <= 1'b0;
                zero_q[i]  <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < STAGES; i++) valid_q[i] <= 1'b0;
            end else if (adv) begin
                valid_q[0] <= accept;
                for (int i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
            end
            if (adv) begin
                for (int i = 0; i < STAGES; i++) begin
                    a_q[i]     <= a_d[i];
                    b_q[i]     <= b_d[i];
                    res_q[i]   <= res_d[i];
                    carry_q[i] <= chunk_cout[i];
                    ovf_q[i]   <= ovf_d[i];
                    zero_q[i]  <= zero_d[i];
                end
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_c      = carry_q[STAGES-1];
    assign out_v      = ovf_q[STAGES-1];
    assign out_z      = zero_q[STAGES-1];
    assign out_n      = res_q[STAGES-1][WIDTH-1];

endmodule
